// File: rtl/carregador_de_instrucoes_if.sv
// Byte-stream input and instruction-memory write port of the program loader.
interface carregador_de_instrucoes_if #(
  parameter int ADDR_WIDTH = 26
);
  logic [7:0]            byte_dado;
  logic                  byte_valido;
  logic                  byte_pronto;
  logic                  escrita;
  logic [ADDR_WIDTH-1:0] endereco;
  logic [31:0]           dado;

  // slave: the loader (consumes bytes, drives the memory write port)
  modport slave (
    input  byte_dado, byte_valido,
    output byte_pronto, escrita, endereco, dado
  );

  // master: byte source plus memory side
  modport master (
    output byte_dado, byte_valido,
    input  byte_pronto, escrita, endereco, dado
  );
endinterface

// File: rtl/carregador_de_instrucoes.sv
// Program loader: parses a framed byte stream (count, big-endian words, XOR
// check byte) and writes the words into instruction memory from address 0.
module carregador_de_instrucoes #(
  parameter int MEM_SIZE   = 30,
  parameter int ADDR_WIDTH = 26
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic                        iniciar,
  carregador_de_instrucoes_if.slave   bus,
  output logic                        ocupado,
  output logic                        concluido,
  output logic [1:0]                  erro
);

  typedef enum logic [2:0] {
    OCIOSO, CAB_H, CAB_L, DADOS, CHECK, FIM, ERRO
  } estado_t;

  localparam logic [15:0] MEM_N   = 16'(MEM_SIZE);
  localparam logic [1:0]  ERR_SUM = 2'b01;
  localparam logic [1:0]  ERR_CNT = 2'b10;

  estado_t               state_q, state_d;
  logic [15:0]           n_q, n_d;
  logic [15:0]           idx_q, idx_d;
  logic [1:0]            bcnt_q, bcnt_d;
  logic [23:0]           asm_q, asm_d;
  logic [7:0]            xor_q, xor_d;
  logic                  escrita_q, escrita_d;
  logic [ADDR_WIDTH-1:0] endereco_q, endereco_d;
  logic [31:0]           dado_q, dado_d;
  logic                  conc_q, conc_d;
  logic [1:0]            erro_q, erro_d;

  logic        pronto;
  logic        aceita;
  logic [15:0] n_rx;
  logic [15:0] idx_inc;

  assign pronto  = (state_q == CAB_H) || (state_q == CAB_L) ||
                   (state_q == DADOS) || (state_q == CHECK);
  assign aceita  = bus.byte_valido && pronto;
  assign n_rx    = {n_q[15:8], bus.byte_dado};
  assign idx_inc = idx_q + 16'd1;

  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    idx_d      = idx_q;
    bcnt_d     = bcnt_q;
    asm_d      = asm_q;
    xor_d      = xor_q;
    escrita_d  = 1'b0;
    endereco_d = endereco_q;
    dado_d     = dado_q;
    conc_d     = conc_q;
    erro_d     = erro_q;

    case (state_q)
      OCIOSO: begin
        if (iniciar) begin
          conc_d  = 1'b0;
          erro_d  = 2'b00;
          idx_d   = '0;
          bcnt_d  = '0;
          xor_d   = '0;
          state_d = CAB_H;
        end
      end
      CAB_H: begin
        if (aceita) begin
          n_d     = {bus.byte_dado, 8'h00};
          xor_d   = xor_q ^ bus.byte_dado;
          state_d = CAB_L;
        end
      end
      CAB_L: begin
        if (aceita) begin
          n_d   = n_rx;
          xor_d = xor_q ^ bus.byte_dado;
          if (n_rx > MEM_N) begin
            // Status is latched on the accepting edge so it is visible while
            // the FSM passes through ERRO/FIM.
            erro_d  = ERR_CNT;
            state_d = ERRO;
          end else if (n_rx == 16'd0) begin
            state_d = CHECK;
          end else begin
            state_d = DADOS;
          end
        end
      end
      DADOS: begin
        if (aceita) begin
          xor_d  = xor_q ^ bus.byte_dado;
          bcnt_d = bcnt_q + 2'd1;
          asm_d  = {asm_q[15:0], bus.byte_dado};
          if (bcnt_q == 2'd3) begin
            escrita_d  = 1'b1;
            dado_d     = {asm_q, bus.byte_dado};
            endereco_d = ADDR_WIDTH'(idx_q);
            idx_d      = idx_inc;
            if (idx_inc == n_q) state_d = CHECK;
          end
        end
      end
      CHECK: begin
        if (aceita) begin
          if (bus.byte_dado == xor_q) begin
            conc_d  = 1'b1;
            state_d = FIM;
          end else begin
            erro_d  = ERR_SUM;
            state_d = ERRO;
          end
        end
      end
      FIM:     state_d = OCIOSO;
      ERRO:    state_d = OCIOSO;
      default: state_d = OCIOSO;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= OCIOSO;
      n_q        <= '0;
      idx_q      <= '0;
      bcnt_q     <= '0;
      asm_q      <= '0;
      xor_q      <= '0;
      escrita_q  <= 1'b0;
      endereco_q <= '0;
      dado_q     <= '0;
      conc_q     <= 1'b0;
      erro_q     <= 2'b00;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      idx_q      <= idx_d;
      bcnt_q     <= bcnt_d;
      asm_q      <= asm_d;
      xor_q      <= xor_d;
      escrita_q  <= escrita_d;
      endereco_q <= endereco_d;
      dado_q     <= dado_d;
      conc_q     <= conc_d;
      erro_q     <= erro_d;
    end
  end

  assign bus.byte_pronto = pronto;
  assign bus.escrita     = escrita_q;
  assign bus.endereco    = endereco_q;
  assign bus.dado        = dado_q;
  assign ocupado         = (state_q != OCIOSO);
  assign concluido       = conc_q;
  assign erro            = erro_q;

endmodule

// File: tb/tb_carregador_de_instrucoes.sv
// Scoreboard bench for the program loader: a frame-level model predicts the
// memory writes and final status; a monitor checks every write strobe.
module tb_carregador_de_instrucoes;
  localparam int MEM_SIZE = 30;
  localparam int AW       = 26;

  typedef logic [7:0] bq_t[$];
  typedef struct packed {
    logic [AW-1:0] a;
    logic [31:0]   d;
  } wr_t;

  logic       clock = 1'b0;
  logic       reset_n = 1'b1;
  logic       iniciar = 1'b0;
  logic       ocupado, concluido;
  logic [1:0] erro;

  carregador_de_instrucoes_if #(.ADDR_WIDTH(AW)) bus ();

  carregador_de_instrucoes #(.MEM_SIZE(MEM_SIZE), .ADDR_WIDTH(AW)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .iniciar   (iniciar),
    .bus       (bus),
    .ocupado   (ocupado),
    .concluido (concluido),
    .erro      (erro)
  );

  always #5 clock = ~clock;

  wr_t           exp_q[$];
  int            n_cmp = 0;
  int            n_bad = 0;
  logic          esc_prev = 1'b0;
  logic          exp_wrote;
  logic [31:0]   exp_last_d;
  logic [AW-1:0] exp_last_a;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, req);
    end
  endtask

  // Monitor: every write strobe must match the oldest predicted write.
  always @(negedge clock) begin
    wr_t e;
    if (bus.escrita === 1'b1) begin
      chk("escrita_one_cycle", {63'd0, esc_prev}, 64'd0);
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_write: addr %0h data %0h, expected no write", bus.endereco, bus.dado);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", 64'(bus.endereco), 64'(e.a));
        chk("wr_data", 64'(bus.dado), 64'(e.d));
      end
    end
    esc_prev = bus.escrita;
  end

  // Frame-level reference: count, words, XOR of all preceding bytes.
  task automatic model(input bq_t fr, output logic ec, output logic [1:0] ee);
    int         n;
    logic [7:0] x;
    wr_t        w;
    n = int'({fr[0], fr[1]});
    x = 8'h00;
    exp_wrote = 1'b0;
    if (n > MEM_SIZE) begin
      ec = 1'b0;
      ee = 2'b10;
      return;
    end
    for (int i = 0; i < n; i++) begin
      w.a = AW'(i);
      w.d = {fr[2+4*i], fr[3+4*i], fr[4+4*i], fr[5+4*i]};
      exp_q.push_back(w);
      exp_wrote  = 1'b1;
      exp_last_a = w.a;
      exp_last_d = w.d;
    end
    for (int i = 0; i < 2 + 4 * n; i++) x ^= fr[i];
    if (fr[2+4*n] == x) begin ec = 1'b1; ee = 2'b00; end
    else                begin ec = 1'b0; ee = 2'b01; end
  endtask

  task automatic mk_frame(input int n, input bit bad, output bq_t fr);
    logic [15:0] nn;
    logic [7:0]  x;
    logic [7:0]  b;
    nn = 16'(n);
    fr = {};
    fr.push_back(nn[15:8]);
    fr.push_back(nn[7:0]);
    if (n <= MEM_SIZE) begin
      for (int i = 0; i < 4 * n; i++) begin
        b = 8'($urandom);
        fr.push_back(b);
      end
      x = 8'h00;
      foreach (fr[i]) x ^= fr[i];
      if (bad) x ^= 8'($urandom_range(1, 255));
      fr.push_back(x);
    end
  endtask

  // Called #1 after a rising edge; returns #1 after the accepting edge.
  task automatic send_byte(input logic [7:0] b, input int gap_pct);
    bit acc;
    int t;
    if (int'($urandom_range(0, 99)) < gap_pct) begin
      bus.byte_valido = 1'b0;
      repeat ($urandom_range(1, 4)) begin @(posedge clock); #1; end
    end
    bus.byte_valido = 1'b1;
    bus.byte_dado   = b;
    acc = 1'b0;
    t   = 0;
    while (!acc && t < 50) begin
      @(negedge clock);
      if (bus.byte_pronto === 1'b1) acc = 1'b1;
      @(posedge clock);
      #1;
      t++;
    end
    if (!acc) begin
      n_cmp++;
      n_bad++;
      $display("FAIL byte_timeout: byte %0h not accepted, expected byte_pronto within 50 cycles", b);
    end
  endtask

  task automatic run_frame(input bq_t fr, input int gap_pct);
    logic       ec;
    logic [1:0] ee;
    int         nb;
    model(fr, ec, ee);
    iniciar = 1'b1;
    @(posedge clock); #1;
    iniciar = 1'b0;
    chk("ocupado_rise", {63'd0, ocupado}, 64'd1);
    chk("status_cleared", {61'd0, concluido, erro}, 64'd0);
    nb = (ee == 2'b10) ? 2 : fr.size();
    for (int i = 0; i < nb; i++) send_byte(fr[i], gap_pct);
    bus.byte_valido = 1'b0;
    chk("concluido", {63'd0, concluido}, {63'd0, ec});
    chk("erro", {62'd0, erro}, {62'd0, ee});
    chk("ocupado_held", {63'd0, ocupado}, 64'd1);
    @(posedge clock); #1;
    chk("ocupado_fall", {63'd0, ocupado}, 64'd0);
    chk("pronto_idle", {63'd0, bus.byte_pronto}, 64'd0);
    repeat (3) begin @(posedge clock); #1; end
    chk("writes_drained", 64'(exp_q.size()), 64'd0);
    chk("status_sticky", {61'd0, concluido, erro}, {61'd0, ec, ee});
    if (exp_wrote) begin
      chk("dado_hold", 64'(bus.dado), 64'(exp_last_d));
      chk("endereco_hold", 64'(bus.endereco), 64'(exp_last_a));
    end
  endtask

  initial begin
    bq_t fr;
    bus.byte_valido = 1'b0;
    bus.byte_dado   = 8'h00;
    #2 reset_n = 1'b0;
    #1;
    chk("reset_outputs", {bus.byte_pronto, bus.escrita, bus.endereco, bus.dado, ocupado, concluido, erro}, 64'd0);
    repeat (2) @(posedge clock);
    @(negedge clock) reset_n = 1'b1;
    @(posedge clock); #1;

    // Count 1
    fr = '{8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h09};
    run_frame(fr, 0);
    chk("t1_dado", 64'(bus.dado), 64'h12345678);
    chk("t1_status", {61'd0, concluido, erro}, 64'b100);

    // Count 2 with gaps
    fr = '{8'h00, 8'h02, 8'h08, 8'h63, 8'h00, 8'h01, 8'hFC, 8'h00, 8'h00, 8'h00, 8'h94};
    run_frame(fr, 60);
    chk("t2_dado", 64'(bus.dado), 64'hFC000000);
    chk("t2_status", {61'd0, concluido, erro}, 64'b100);

    // Bad check byte
    fr = '{8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h0A};
    run_frame(fr, 0);
    chk("t3_status", {61'd0, concluido, erro}, 64'b001);

    // Count overflow
    fr = '{8'h00, 8'h1F};
    run_frame(fr, 0);
    chk("t4_status", {61'd0, concluido, erro}, 64'b010);

    // Empty program
    fr = '{8'h00, 8'h00, 8'h00};
    run_frame(fr, 30);
    chk("t5_status", {61'd0, concluido, erro}, 64'b100);

    // Full memory
    mk_frame(MEM_SIZE, 1'b0, fr);
    run_frame(fr, 10);

    // Reset mid-load after the 2nd payload byte
    iniciar = 1'b1;
    @(posedge clock); #1;
    iniciar = 1'b0;
    send_byte(8'h00, 0);
    send_byte(8'h01, 0);
    send_byte(8'h12, 0);
    send_byte(8'h34, 0);
    bus.byte_valido = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    chk("midload_reset", {bus.byte_pronto, bus.escrita, bus.endereco, bus.dado, ocupado, concluido, erro}, 64'd0);
    @(negedge clock) reset_n = 1'b1;
    @(posedge clock); #1;
    fr = '{8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h09};
    run_frame(fr, 0);
    chk("after_reset_status", {61'd0, concluido, erro}, 64'b100);

    // Randomized frames
    for (int k = 0; k < 30; k++) begin
      int sel;
      int n;
      sel = int'($urandom_range(0, 9));
      if (sel == 0)      n = int'($urandom_range(MEM_SIZE + 1, 65535));
      else if (sel == 1) n = MEM_SIZE;
      else               n = int'($urandom_range(0, 8));
      mk_frame(n, ($urandom_range(0, 3) == 0), fr);
      run_frame(fr, int'($urandom_range(0, 50)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
